// File: rtl/tpu_pkg.sv
// Shared types and sizing for the TPU operand feeder and MAC array.
package tpu_pkg;

  localparam int unsigned array_size   = 4;
  localparam int unsigned flush_cycles = 2 * array_size;

  typedef logic [7:0]  operand_t;
  typedef logic [23:0] psum_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_e;

endpackage

// File: rtl/tpu_feeder_if.sv
// Operand-side handshake plus skewed array-edge outputs of the feeder.
interface tpu_feeder_if;
  import tpu_pkg::*;

  logic                           in_valid;
  logic                           in_ready;
  logic                           in_last;
  operand_t [1:array_size]        in_d;
  operand_t [1:array_size]        in_w;
  operand_t [1:array_size]        d;
  operand_t [1:array_size]        w;
  logic                           busy;
  logic                           done;
  logic [7:0]                     beat_count;

  // Operand buffer / controller side.
  modport master (
    output in_valid, in_last, in_d, in_w,
    input  in_ready, d, w, busy, done, beat_count
  );

  // Feeder side.
  modport slave (
    input  in_valid, in_last, in_d, in_w,
    output in_ready, d, w, busy, done, beat_count
  );

endinterface

// File: rtl/skew_lane.sv
// Fixed-depth byte delay line; stage 1 loads din when en, else a zero bubble.
module skew_lane #(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] sr [1:DEPTH];

  // Shift one stage per cycle; zeros enter whenever nothing is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i <= DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[1] <= en ? din : 8'd0;
      for (int unsigned i = 2; i <= DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH];

endmodule

// File: rtl/tpu_feeder.sv
// Diagonal-skew operand sequencer for the systolic array, with tile flush.
module tpu_feeder
  import tpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  tpu_feeder_if.slave  bus
);

  localparam logic [7:0] flush_load = 8'(flush_cycles - 1);

  feeder_state_e               state;
  logic [7:0]                  flush_cnt;
  logic [7:0]                  beat_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        accept;
  operand_t [1:array_size]     d_q;
  operand_t [1:array_size]     w_q;

  // Ready is a decode of the state register, forced low during reset.
  assign bus.in_ready = ~rst & ((state == IDLE) | (state == STREAM));
  assign accept       = bus.in_valid & bus.in_ready;

  // Lane k of data and weights is delayed k cycles.
  for (genvar k = 1; k <= int'(array_size); k++) begin : g_lane
    skew_lane #(.DEPTH(k)) u_d (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (bus.in_d[k]),
      .dout (d_q[k])
    );
    skew_lane #(.DEPTH(k)) u_w (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (bus.in_w[k]),
      .dout (w_q[k])
    );
  end

  // Tile FSM with flush down-counter, beat counter and registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      beat_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            beat_q <= 8'd1;
            busy_q <= 1'b1;
            if (bus.in_last) begin
              state     <= FLUSH;
              flush_cnt <= flush_load;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            beat_q <= beat_q + 8'd1;
            if (bus.in_last) begin
              state     <= FLUSH;
              flush_cnt <= flush_load;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == 8'd0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - 8'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          beat_q <= '0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.d          = d_q;
  assign bus.w          = w_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.beat_count = beat_q;

endmodule

// File: tb/tb_tpu_feeder.sv
// Directed self-checking bench for tpu_feeder.
module tb_tpu_feeder;
  import tpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpu_feeder_if bus ();
  tpu_feeder dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input int bd, input int bw);
    bus.in_valid = v;
    bus.in_last  = l;
    for (int k = 1; k <= int'(array_size); k++) begin
      bus.in_d[k] = 8'(bd + k);
      bus.in_w[k] = 8'(bw + k);
    end
  endtask

  // Returns at the negedge of the DONE cycle, or after budget cycles.
  task automatic wait_done(input int budget, input string tag);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (bus.done !== 1'b1 && i < budget);
    chk({tag, " done"}, 32'(bus.done), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 1; k <= int'(array_size); k++) begin
      chk($sformatf("%s d%0d", tag, k), 32'(bus.d[k]), 32'd0);
      chk($sformatf("%s w%0d", tag, k), 32'(bus.w[k]), 32'd0);
    end
    chk({tag, " beat"}, 32'(bus.beat_count), 32'd0);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " done"}, 32'(bus.done), 32'd0);
    chk({tag, " ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    drive(1'b0, 1'b0, 0, 0);
    #2;
    chk_zero("por");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("por ready", 32'(bus.in_ready), 32'd1);

    // Single vector with in_last.
    drive(1'b1, 1'b1, 0, 4);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b1, 77, 88);
      for (int k = 1; k <= int'(array_size); k++) begin
        chk($sformatf("single d%0d c%0d", k, c), 32'(bus.d[k]), (c == k) ? 32'(k) : 32'd0);
        chk($sformatf("single w%0d c%0d", k, c), 32'(bus.w[k]), (c == k) ? 32'(4 + k) : 32'd0);
      end
      chk($sformatf("single done c%0d", c), 32'(bus.done), (c == 9) ? 32'd1 : 32'd0);
      chk($sformatf("single ready c%0d", c), 32'(bus.in_ready), (c == 10) ? 32'd1 : 32'd0);
      chk($sformatf("single busy c%0d", c), 32'(bus.busy), (c <= 9) ? 32'd1 : 32'd0);
      if (c == 9) chk("single beat", 32'(bus.beat_count), 32'd1);
    end

    // Four back-to-back vectors, last on the fourth.
    drive(1'b1, 1'b0, 10, 110);
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 1; k <= int'(array_size); k++) begin
        n = c - k + 1;
        chk($sformatf("b2b d%0d c%0d", k, c), 32'(bus.d[k]),
            (n >= 1 && n <= 4) ? 32'(10 * n + k) : 32'd0);
        chk($sformatf("b2b w%0d c%0d", k, c), 32'(bus.w[k]),
            (n >= 1 && n <= 4) ? 32'(100 + 10 * n + k) : 32'd0);
      end
      chk($sformatf("b2b ready c%0d", c), 32'(bus.in_ready),
          (c <= 3 || c >= 13) ? 32'd1 : 32'd0);
      chk($sformatf("b2b done c%0d", c), 32'(bus.done), (c == 12) ? 32'd1 : 32'd0);
      if (c <= 3) chk($sformatf("b2b beat c%0d", c), 32'(bus.beat_count), 32'(c));
      if (c == 12) chk("b2b beat done", 32'(bus.beat_count), 32'd4);
      if (c < 4) drive(1'b1, (c == 3), 10 * (c + 1), 100 + 10 * (c + 1));
      else       drive(1'b0, 1'b0, 55, 66);
    end

    // Bubble between two accepts.
    drive(1'b1, 1'b0, 20, 40);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 1; k <= int'(array_size); k++) begin
        chk($sformatf("bub d%0d c%0d", k, c), 32'(bus.d[k]),
            (c == k) ? 32'(20 + k) : (c == k + 2) ? 32'(30 + k) : 32'd0);
        chk($sformatf("bub w%0d c%0d", k, c), 32'(bus.w[k]),
            (c == k) ? 32'(40 + k) : (c == k + 2) ? 32'(50 + k) : 32'd0);
      end
      if (c == 2) begin
        chk("bub ready stream", 32'(bus.in_ready), 32'd1);
        chk("bub busy stream", 32'(bus.busy), 32'd1);
        chk("bub beat stream", 32'(bus.beat_count), 32'd1);
      end
      if (c == 3) begin
        chk("bub beat last", 32'(bus.beat_count), 32'd2);
        chk("bub ready flush", 32'(bus.in_ready), 32'd0);
      end
      if (c == 1)      drive(1'b0, 1'b1, 99, 99);
      else if (c == 2) drive(1'b1, 1'b1, 30, 50);
      else             drive(1'b0, 1'b0, 0, 0);
    end
    wait_done(20, "bub");
    chk("bub beat done", 32'(bus.beat_count), 32'd2);
    @(negedge clk);

    // 257 accepts: beat_count wraps through 0 and ends at 1.
    drive(1'b1, 1'b0, 1, 2);
    for (int i = 1; i <= 257; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1)   chk("wrap beat 1", 32'(bus.beat_count), 32'd1);
      if (i == 256) chk("wrap beat 256", 32'(bus.beat_count), 32'd0);
      if (i < 256)       drive(1'b1, 1'b0, i, i);
      else if (i == 256) drive(1'b1, 1'b1, 3, 4);
    end
    chk("wrap beat 257", 32'(bus.beat_count), 32'd1);
    chk("wrap ready flush", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 1'b1, 60, 70);
    wait_done(20, "wrap");
    chk("wrap beat done", 32'(bus.beat_count), 32'd1);
    chk("wrap ready done", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("reuse ready idle", 32'(bus.in_ready), 32'd1);
    chk("reuse beat idle", 32'(bus.beat_count), 32'd0);
    chk("reuse busy idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 0);
    chk("reuse beat", 32'(bus.beat_count), 32'd1);
    chk("reuse busy", 32'(bus.busy), 32'd1);
    chk("reuse d1", 32'(bus.d[1]), 32'd61);
    wait_done(20, "reuse");
    @(negedge clk);

    // Reset in the third cycle after in_last, with data in flight.
    drive(1'b1, 1'b1, 80, 90);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rstf d3 before", 32'(bus.d[3]), 32'd83);
    rst = 1'b1;
    #1;
    chk_zero("rstf");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstf ready after", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (16) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    chk("rstf no done", 32'(seen), 32'd0);
    chk("rstf busy idle", 32'(bus.busy), 32'd0);
    drive(1'b1, 1'b1, 0, 4);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 0);
    chk("rstf next d1", 32'(bus.d[1]), 32'd1);
    chk("rstf next w1", 32'(bus.w[1]), 32'd5);
    chk("rstf next busy", 32'(bus.busy), 32'd1);
    wait_done(20, "rstf next");
    chk("rstf next beat", 32'(bus.beat_count), 32'd1);
    @(negedge clk);
    chk("rstf next idle busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tpu_feeder.md
# tpu_feeder

Operand sequencer that drives the systolic MAC array from the input side. It accepts one column-vector of data and one of weights per handshake and applies the diagonal skew the array requires: lane k is delayed k cycles. It inserts zero bubbles whenever no vector is accepted, and after the last vector of a tile flushes zeros until the array has drained. It sits between the operand buffers and the array's `d`/`w` edge inputs and reports tile completion to the controller.

## Interface
- `arraySize`, 4, number of lanes; equals the array dimension.
- `FLUSH_CYCLES`, 2*arraySize, zero-fill cycles after the last vector before `done`; legal range 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  an operand vector is presented.
- `in_ready`  out  1  feeder can accept this cycle.
- `in_last`  in  1  qualifies `in_valid`; marks the final vector of a tile.
- `in_d[1:arraySize]`  in  8 each  data lanes, unsigned bytes.
- `in_w[1:arraySize]`  in  8 each  weight lanes, unsigned bytes.
- `d[1:arraySize]`  out  8 each  skewed data to the array's data edge.
- `w[1:arraySize]`  out  8 each  skewed weights to the array's weight edge.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a tile has fully drained.
- `beat_count`  out  8  vectors accepted in the current tile; wraps modulo 256.

## Operation
- Accept means `in_valid & in_ready` at a rising edge. `in_ready` is 1 in IDLE and STREAM, 0 in FLUSH and DONE, and 0 while `rst` is high.
- Skew pipeline:
  - Lane k of both `d` and `w` is a k-stage shift register of bytes.
  - Each cycle, stage 1 of lane k loads `in_d[k]`/`in_w[k]` if an accept occurs, else 0.
  - `d[k]`/`w[k]` are the registered stage-k outputs. Outputs are never combinational from inputs.
- FSM states and transitions:
  - IDLE: accept without `in_last` → STREAM. Accept with `in_last` → FLUSH. No accept → stay.
  - STREAM: accept with `in_last` → FLUSH. Otherwise stay. A cycle with no accept inserts a zero bubble and does not end the tile.
  - FLUSH: a down-counter loads FLUSH_CYCLES-1 on entry and decrements each cycle; zeros enter all lanes. At counter 0 → DONE.
  - DONE: `done`=1 for exactly this cycle → IDLE.
- `beat_count` behaviour:
  - Increments on each accept.
  - Clears on the transition DONE→IDLE.
  - An accept in IDLE loads 1.
- `in_d`/`in_w`/`in_last` are ignored when `in_valid` is low. `in_last` without `in_valid` has no effect.
- Reset:
  - While `rst` is high, asynchronously: all skew stages, `d`, `w`, `beat_count`, and the flush counter go to 0; state goes to IDLE; `busy`=0, `done`=0, `in_ready`=0.
  - Reset mid-tile discards in-flight data with no `done`.
  - The first accept is possible on the first rising edge after `rst` falls.

## Timing
- Vector accepted at edge t: `d[k]`/`w[k]` show it during cycle t+k, i.e. after edge t+k-1.
  - Lane 1 latency is 1 cycle; lane arraySize latency is arraySize cycles.
- Back-to-back accepts give one vector per cycle with no bubbles. Maximum throughput is 1 vector/clk.
- Tile ending with `in_last` accepted at edge t:
  - FLUSH occupies cycles t+1 .. t+FLUSH_CYCLES.
  - DONE (`done`=1) is cycle t+FLUSH_CYCLES+1.
  - The next accept is possible at the edge ending that DONE cycle + 1, i.e. the first IDLE cycle.
- `busy` rises the cycle after the first accept and falls in the cycle after DONE.

## Structure
- Shared package `tpu_pkg`:
  - `typedef logic [7:0] operand_t`
  - `typedef logic [23:0] psum_t`, reused by the array output side.
  - The FSM state enum `feeder_state_e` {IDLE, STREAM, FLUSH, DONE}.
- One sub-module, `skew_lane`:
  - Parameter DEPTH; an 8-bit shift register with async reset, zero-fill input, and a load enable.
  - Instantiated twice per lane (data and weight) in a generate loop, with DEPTH=k.
- FSM, flush counter and beat counter live in `tpu_feeder` itself.

## Test plan
- Reset check: assert `rst` mid-cycle with nonzero pipeline content → all `d`/`w`, `beat_count`, `busy`, `done` are 0 immediately. After release, `in_ready`=1.
- Single vector, arraySize=4, `in_d`={1,2,3,4}, `in_w`={5,6,7,8}, `in_last`=1 accepted at edge 0:
  - `d[1]`=1/`w[1]`=5 in cycle 1, `d[2]`=2 in cycle 2, `d[3]`=3 in cycle 3, `d[4]`=4/`w[4]`=8 in cycle 4; every other cycle shows 0.
  - `done` pulses in cycle 9, with FLUSH_CYCLES=8.
- Four back-to-back vectors with `in_d[k]`=10·n+k (n = 1..4), last on n=4:
  - `d[k]` equals 10·n+k in cycle n+k-1.
  - `beat_count`=4 at DONE; `in_ready`=0 during FLUSH.
- Bubble insertion: accepts at edges 0 and 2 with `in_valid` low at edge 1 → every lane shows a 0 between the two vectors. State stays STREAM.
- Wrap and reuse: 256 accepts then `in_last` → `beat_count` wraps through 0 and ends at 1. A new tile accepted in the first IDLE cycle after DONE starts `beat_count` at 1.
- Reset mid-FLUSH: `rst` pulse in cycle t+3 → no `done` ever pulses for that tile, state is IDLE, and the next tile runs normally.
